// File: rtl/counter_4bit_updn.sv
// rtl/counter_4bit_updn.sv - 4-bit modulo up/down counter with load, clear, tc, wrap pulse and sticky ovf (optional COUNTER_SATURATE_EN)
module counter_4bit_updn #(
    parameter int WIDTH   = 4,
    parameter int MOD_MAX = 15
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrapped,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD_MAX);
    localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrapped_q, wrapped_d;
    logic             ovf_q, ovf_d;
    logic             step;
    logic             at_max;
    logic             at_zero;

    // Terminal count: an enabled step (not overridden by clear/load) sitting at the bound of its direction.
    always_comb begin
        at_max  = (count_q == MAX_V);
        at_zero = (count_q == '0);
        step    = en & ~clear & ~load;
        tc      = step & ((up_dn & at_max) | (~up_dn & at_zero));
    end

    // Next-state: clear beats load beats count; a step at the bound either wraps or saturates.
    always_comb begin
        count_d   = count_q;
        wrapped_d = 1'b0;
        ovf_d     = ovf_q;
        if (clear) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (load) begin
            count_d = (load_val > MAX_V) ? MAX_V : load_val;
        end else if (en) begin
            if (tc) begin
`ifdef COUNTER_SATURATE_EN
                count_d = count_q;
                ovf_d   = 1'b1;
`else
                count_d   = up_dn ? '0 : MAX_V;
                wrapped_d = 1'b1;
                ovf_d     = 1'b1;
`endif
            end else begin
                count_d = up_dn ? (count_q + ONE_V) : (count_q - ONE_V);
            end
        end
    end

    // State registers; reset clears everything immediately without a clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q   <= '0;
            wrapped_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            wrapped_q <= wrapped_d;
            ovf_q     <= ovf_d;
        end
    end

    assign count   = count_q;
    assign wrapped = wrapped_q;
    assign ovf     = ovf_q;

endmodule

// File: doc/counter_4bit_updn.md
# counter_4bit_updn

Synchronous 4-bit modulo up/down counter for the counter datapath. It holds its state bits in rising-edge D flip-flops, one per bit. It accepts enable, direction, synchronous clear and parallel load controls. It produces the count, a combinational terminal-count carry for cascading, a registered wrap pulse, and a sticky overflow flag for the debug display logic downstream.

## Interface
- `WIDTH`, 4: count width in bits; only 4 is supported.
- `MOD_MAX`, 15: highest count value; the count range is 0..MOD_MAX, and MOD_MAX must be ≤ 2^WIDTH−1.
- `clk`  input  1  system clock; all state updates on its rising edge.
- `reset_n`  input  1  one clock; reset is asynchronous and active-low.
- `en`  input  1  count enable; one step per cycle while high.
- `up_dn`  input  1  direction: 1 = up, 0 = down.
- `clear`  input  1  synchronous clear to 0.
- `load`  input  1  synchronous parallel load.
- `load_val`  input  WIDTH  value to load.
- `count`  output  WIDTH  current count.
- `tc`  output  1  terminal count, combinational (carry-out).
- `wrapped`  output  1  registered one-cycle pulse after a wrap.
- `ovf`  output  1  sticky overflow/underflow flag.

## Operation
- Control priority, highest first: `reset_n` low > `clear` > `load` > `en`. If none is active, the count holds.
- `clear`: next count = 0 and `ovf` is cleared, regardless of `load` and `en`.
- `load`: next count = `load_val`. If `load_val` > MOD_MAX, the count is clamped to MOD_MAX. `ovf` is unchanged.
- `en` with up_dn = 1: count + 1. At MOD_MAX, the next count is 0 (a wrap).
- `en` with up_dn = 0: count − 1. At 0, the next count is MOD_MAX (a wrap).
- `tc` = en & ~clear & ~load & ((up_dn & count==MOD_MAX) | (~up_dn & count==0)).
- `wrapped` is set for exactly one cycle following any cycle in which a wrap occurred. Otherwise it is 0.
- `ovf` is set on the cycle following a wrap and stays set until `clear` or reset.
- Direction change while enabled takes effect on the same edge; there is no dead cycle.
- All arithmetic is WIDTH bits, unsigned, with no intermediate wider than WIDTH+1.

## Timing
- Reset (asynchronous assert, any time): count = 0, wrapped = 0, ovf = 0. `tc` then follows its combinational equation.
- Reset deassertion is expected to be synchronised externally. The first count step happens on the first rising edge with reset_n high and en high.
- Reset asserted mid-count forces all outputs to reset values immediately, without waiting for a clock edge.
- Count latency: one cycle from `en`/`load`/`clear` sampled high to the new `count` value.
- `tc` has zero latency; it is valid in the same cycle as its inputs.
- `wrapped` and `ovf` rise one cycle after the wrap edge, i.e. in the same cycle that `count` shows the post-wrap value.
- `clear` and `load` in the same cycle: clear wins, and `wrapped` stays 0.
- `load` in the same cycle as a would-be wrap: no wrap occurs, and `tc` = 0.

## Configuration
- Macro `COUNTER_SATURATE_EN`.
- Defined: the counter saturates instead of wrapping. Up at MOD_MAX holds MOD_MAX; down at 0 holds 0. `wrapped` is never asserted. `ovf` sets on the cycle following any enabled step attempted at the bound. `tc` keeps the same equation.
- Undefined (default): modulo wrap behaviour as described in Operation.

## Test plan
- Reset mid-count: count at 9, pull reset_n low between clock edges -> count = 0, wrapped = 0, ovf = 0 immediately, and they stay there while reset_n is low.
- Up wrap: load 14, en = 1, up_dn = 1 for 3 cycles -> count 14, 15, 0, 1. `tc` = 1 only while count = 15. `wrapped` = 1 only in the cycle count = 0. `ovf` = 1 from then on.
- Down wrap with MOD_MAX = 9: load 1, down for 3 cycles -> count 1, 0, 9, 8. `tc` = 1 while count = 0. `ovf` sets.
- Load clamp and priority: MOD_MAX = 9, load_val = 13 -> count = 9. In a later cycle, clear = load = en = 1 -> count = 0 and ovf = 0.
- Saturate build (`COUNTER_SATURATE_EN`): load 15, up for 2 cycles -> count stays 15, wrapped stays 0, ovf = 1 after the first attempted step.
- Direction flip: count 5, up one cycle then down one cycle -> count 6 then 5, with no hold cycle in between.
